mc_main_fsm: RTL

Main control FSM of the multi-cycle RV32I core. It is the successor of the combinational ImmSrc decoder, generalised to a full Moore-style state machine. It adds jalr/auipc/all six branch conditions, a memory-ready handshake and illegal-opcode trapping. It sits in the controller beside the ALU decoder and drives every datapath enable and mux select from the registered instruction (IR).

---
 rtl/mc_main_fsm_pkg.sv | 92 +++++++++
 rtl/mc_main_fsm_imm_src_gen.sv | 28 ++
 rtl/mc_main_fsm.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mc_main_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I main control FSM: opcodes, states,
// datapath select codes and the branch-condition helpers.
package mc_main_fsm_pkg;

   typedef enum logic [6:0] {
      lw_op         = 7'b0000011,
      i_type_alu_op = 7'b0010011,
      auipc_op      = 7'b0010111,
      sw_op         = 7'b0100011,
      r_type_op     = 7'b0110011,
      lui_op        = 7'b0110111,
      branch_op     = 7'b1100011,
      jalr_op       = 7'b1100111,
      jal_op        = 7'b1101111
   } opcodetype;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALRADR  = 4'd11,
      LUI      = 4'd12,
      AUIPC    = 4'd13,
      TRAP     = 4'd14
   } statetype;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // funct3 010/011 have no branch meaning in RV32I and must trap.
   function automatic logic branch_f3_valid(input logic [2:0] funct3);
      logic valid;
      case (funct3)
         F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: valid = 1'b1;
         default:                                          valid = 1'b0;
      endcase
      return valid;
   endfunction

   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       less_than,
                                         input logic       less_than_u);
      logic taken;
      case (funct3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = ~zero;
         F3_BLT:  taken = less_than;
         F3_BGE:  taken = ~less_than;
         F3_BLTU: taken = less_than_u;
         F3_BGEU: taken = ~less_than_u;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/mc_main_fsm_imm_src_gen.sv
// Combinational opcode -> ImmSrc map; anything unknown, R-type or disabled
// falls back to the I-type code.
module imm_src_gen
   import mc_main_fsm_pkg::*;
#(
   parameter bit SUPPORT_UTYPE = 1'b1,
   parameter int IMM_SRC_W     = 3
) (
   input  logic [6:0]           op,
   output logic [IMM_SRC_W-1:0] imm_src
);

   logic [2:0] code;

   always_comb begin
      code = IMM_I;
      case (op)
         sw_op:             code = IMM_S;
         branch_op:         code = IMM_B;
         jal_op:            code = IMM_J;
         lui_op, auipc_op:  code = SUPPORT_UTYPE ? IMM_U : IMM_I;
         default:           code = IMM_I;
      endcase
   end

   assign imm_src = IMM_SRC_W'(code);

endmodule

// File: rtl/mc_main_fsm.sv
// Main Moore-style control FSM of the multi-cycle RV32I core; drives every
// datapath enable and mux select from the registered instruction.
module mc_main_fsm
   import mc_main_fsm_pkg::*;
#(
   parameter bit SUPPORT_JALR  = 1'b1,
   parameter bit SUPPORT_UTYPE = 1'b1,
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter int IMM_SRC_W     = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 Zero,
   input  logic                 LessThan,
   input  logic                 LessThanU,
   input  logic                 mem_ready,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ALUOp,
   output logic [IMM_SRC_W-1:0] ImmSrc,
   output logic                 RegWrite,
   output logic                 Illegal,
   output logic [3:0]           state_o
);

   statetype state;
   statetype state_next;
   logic     ready;

   assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

   imm_src_gen #(
      .SUPPORT_UTYPE(SUPPORT_UTYPE),
      .IMM_SRC_W    (IMM_SRC_W)
   ) u_imm_src_gen (
      .op     (op),
      .imm_src(ImmSrc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RD2;
      ALUOp      = ALUOP_ADD;

      case (state)
         FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = ready;
            PCWrite   = ready;
            if (ready) state_next = DECODE;
         end
         // The adder here forms OldPC + imm so BRANCH/JAL find their target in ALUOut.
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               lw_op, sw_op:  state_next = MEMADR;
               r_type_op:     state_next = EXECUTER;
               i_type_alu_op: state_next = EXECUTEI;
               branch_op:     state_next = branch_f3_valid(funct3) ? BRANCH : TRAP;
               jal_op:        state_next = JAL;
               jalr_op:       state_next = SUPPORT_JALR ? JALRADR : TRAP;
               lui_op:        state_next = SUPPORT_UTYPE ? LUI : TRAP;
               auipc_op:      state_next = SUPPORT_UTYPE ? AUIPC : TRAP;
               default:       state_next = TRAP;
            endcase
         end
         MEMADR: begin
            ALUSrcA    = SRCA_RD1;
            ALUSrcB    = SRCB_IMM;
            state_next = (op == sw_op) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (ready) state_next = MEMWB;
         end
         MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            state_next = FETCH;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (ready) state_next = FETCH;
         end
         EXECUTER: begin
            ALUSrcA    = SRCA_RD1;
            ALUOp      = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA    = SRCA_RD1;
            ALUSrcB    = SRCB_IMM;
            ALUOp      = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: begin
            RegWrite   = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            ALUSrcA    = SRCA_RD1;
            ALUOp      = ALUOP_SUB;
            PCWrite    = branch_taken(funct3, Zero, LessThan, LessThanU);
            state_next = FETCH;
         end
         // Shared by jal and the second half of jalr: PC <- ALUOut, rd <- OldPC + 4 next.
         JAL: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            PCWrite    = 1'b1;
            state_next = ALUWB;
         end
         JALRADR: begin
            ALUSrcA    = SRCA_RD1;
            ALUSrcB    = SRCB_IMM;
            state_next = JAL;
         end
         LUI: begin
            ALUSrcA    = SRCA_ZERO;
            ALUSrcB    = SRCB_IMM;
            state_next = ALUWB;
         end
         AUIPC: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_IMM;
            state_next = ALUWB;
         end
         TRAP: begin
            state_next = TRAP;
         end
         default: begin
            state_next = TRAP;
         end
      endcase

      // Reset must kill every write strobe immediately, even mid-access.
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
      end
   end

   assign Illegal = (state == TRAP);
   assign state_o = state;

endmodule
